// File: rtl/pla_wim_scan.sv
// Multiplexed multi-digit driver for the wim 4-in/7-out decode: double-buffered digit codes, SHOW/GAP scan.
// Optional leading-zero blanking is enabled by defining PLA_WIM_SCAN_LZB_EN.
module pla_wim_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV + 1);
  localparam logic [DIGITS-1:0] SEL0 = DIGITS'(1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t                   state;
  logic [DIGITS-1:0][3:0]   shadow, active;
  logic                     pend;
  logic [IW-1:0]            idx, nidx;
  logic [CW-1:0]            cnt;
  logic [6:0]               next_pat;

  function automatic logic [6:0] wim(input logic [3:0] c);
    case (c)
      4'd0:    wim = 7'h6F;
      4'd1:    wim = 7'h24;
      4'd2:    wim = 7'h5D;
      4'd3:    wim = 7'h75;
      4'd4:    wim = 7'h37;
      4'd5:    wim = 7'h73;
      4'd6:    wim = 7'h7B;
      4'd7:    wim = 7'h35;
      4'd8:    wim = 7'h7F;
      4'd9:    wim = 7'h77;
      default: wim = 7'h00;
    endcase
  endfunction

`ifdef PLA_WIM_SCAN_LZB_EN
  logic [DIGITS-1:0] blank;

  // Bit i set when digit i and every digit above it are zero; digit 0 stays visible.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [DIGITS-1:0][3:0] w);
    logic run;
    run     = 1'b1;
    lz_mask = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run        = run & (w[i] == 4'd0);
      lz_mask[i] = run;
    end
  endfunction
`endif

  assign in_ready = ~pend;
  assign nidx     = idx + 1'b1;

  always_comb begin
    next_pat = wim(active[nidx]);
`ifdef PLA_WIM_SCAN_LZB_EN
    if (blank[nidx]) next_pat = 7'h00;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shadow     <= '0;
      active     <= '0;
      pend       <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      seg        <= '0;
      dig_sel    <= '0;
      frame_done <= 1'b0;
`ifdef PLA_WIM_SCAN_LZB_EN
      blank      <= '0;
`endif
    end else begin
      // Accept and swap are mutually exclusive through pend.
      if (in_valid && !pend) begin
        shadow <= in_data;
        pend   <= 1'b1;
      end
      frame_done <= 1'b0;
      case (state)
        IDLE: if (pend) begin
          active  <= shadow;
          pend    <= 1'b0;
`ifdef PLA_WIM_SCAN_LZB_EN
          blank   <= lz_mask(shadow);
`endif
          state   <= SHOW;
          idx     <= '0;
          cnt     <= '0;
          seg     <= wim(shadow[0]);
          dig_sel <= SEL0;
        end
        SHOW: begin
          if (cnt == CW'(SCAN_DIV - 1)) begin
            state      <= GAP;
            seg        <= '0;
            dig_sel    <= '0;
            frame_done <= (idx == IW'(DIGITS - 1));
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          state <= SHOW;
          cnt   <= '0;
          if (idx != IW'(DIGITS - 1)) begin
            idx     <= nidx;
            seg     <= next_pat;
            dig_sel <= SEL0 << nidx;
          end else begin
            // Frame boundary: a pending word becomes visible from digit 0 onward.
            idx     <= '0;
            dig_sel <= SEL0;
            seg     <= wim(pend ? shadow[0] : active[0]);
            if (pend) begin
              active <= shadow;
              pend   <= 1'b0;
`ifdef PLA_WIM_SCAN_LZB_EN
              blank  <= lz_mask(shadow);
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pla_wim_scan.md
# pla_wim_scan

Time-multiplexed, multi-digit display driver built around the wim 4-in/7-out decode function. Accepts a packed word of DIGITS 4-bit codes over a valid/ready handshake into a shadow buffer and swaps it into the active buffer at frame boundaries. Scans the digits one at a time, with a blanking gap between digits, producing a registered 7-bit pattern and a one-hot digit select. Sits between the status/counter logic and the display pads.

## Interface
- DIGITS, 4, number of multiplexed digits (2..16)
- SCAN_DIV, 16, cycles each digit is shown (>=1)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  shadow buffer empty; accept when in_valid & in_ready
- in_data  input  4*DIGITS  digit codes; bits [4i+3:4i] = digit i, bit 4i+3 = x0 (MSB)
- seg  output  7  decoded pattern z[6:0], registered
- dig_sel  output  DIGITS  one-hot digit enable, registered
- frame_done  output  1  one-cycle pulse at end of each frame

## Operation
- Decode table, code -> z[6:0] hex: 0->6F, 1->24, 2->5D, 3->75, 4->37, 5->73, 6->7B, 7->35, 8->7F, 9->77, 10..15->00.
- Buffers: shadow (4*DIGITS), pend flag, active (4*DIGITS). in_ready = ~pend.
- Accept: shadow <= in_data, pend <= 1. Swap: active <= shadow, pend <= 0.
- FSM states:
  - IDLE: seg=0, dig_sel=0. Stays until pend=1, then swap, go SHOW at digit 0.
  - SHOW: dig_sel = 1<<idx, seg = decode(active digit idx). After exactly SCAN_DIV cycles, go GAP.
  - GAP: one cycle, seg=0, dig_sel=0.
    - If idx < DIGITS-1: idx++, go SHOW.
    - Else: idx <= 0, frame_done=1; swap if pend=1; go SHOW.
- Accept and swap can never coincide: accept needs pend=0, swap needs pend=1.
- After the first load, the block never returns to IDLE; it rescans the active data indefinitely.
- Dwell counter: width $clog2(SCAN_DIV+1), counts 0..SCAN_DIV-1, cleared on entry to SHOW.

## Timing
- Reset values: seg=0, dig_sel=0, frame_done=0, in_ready=1; state IDLE, idx=0, pend=0, shadow=0, active=0.
- Reset is asynchronous. Asserting it mid-frame immediately clears all outputs and discards shadow data.
- Load from IDLE: accept at edge k; pend=1 after k; swap and SHOW digit 0 after edge k+1. seg/dig_sel show digit 0 from edge k+1 (two edges after the data is presented).
- in_ready drops the cycle after an accept. It rises the cycle after a swap.
- Frame period = DIGITS*(SCAN_DIV+1) cycles. frame_done is high during the last GAP cycle only.
- New data takes effect on the first SHOW cycle after the frame_done cycle. It never changes mid-frame.
- seg and dig_sel change on the same edge. dig_sel is never multi-hot.

## Configuration
- PLA_WIM_SCAN_LZB_EN defined: leading-zero blanking.
  - While scanning from digit DIGITS-1 downward, each digit whose code is 0 and all of whose higher digits are 0 shows seg=0. dig_sel is still asserted for that digit.
  - Digit 0 is never blanked.
  - The blank mask is computed from the active buffer and updated on swap.
- Undefined: every digit is decoded per the table, including code 0 -> 6F.

## Test plan
- Reset then idle: no in_valid for 100 cycles -> seg=00, dig_sel=0, in_ready=1, frame_done never pulses.
- DIGITS=4, SCAN_DIV=3, load in_data=0x9820 -> digit sequence 6F, 5D, 7F, 77, each held 3 cycles with a 1-cycle 00 gap between digits. frame_done pulses every 16 cycles.
- Load 0x1234 mid-frame, then present 0x5555 with in_valid held high -> in_ready=0 until the frame_done cycle. 0x1234 is displayed from the next frame; 0x5555 is accepted the cycle after and displayed one frame later.
- Codes A..F (in_data=0xFEDC) -> seg=00 in every SHOW slot, while dig_sel still cycles 1, 2, 4, 8.
- With PLA_WIM_SCAN_LZB_EN, load 0x0070:
  - Digits 3 and 2 show 00.
  - Digit 1 shows 35.
  - Digit 0 shows 6F.
  - Without the macro, digits 3 and 2 show 6F.
- Deassert rst_n during SHOW of digit 2 -> seg, dig_sel and frame_done go to 0 with no clock edge. After release, the block stays in IDLE until a new load.
